// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop RX synchronizer, falling-edge start detect, mid-bit sampling.
// Optional stop-bit check with framing_err output when UART_RX_FRAME_CHK_EN is defined.
module uart_rx #(
  parameter int BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy
`ifdef UART_RX_FRAME_CHK_EN
  ,
  output logic       framing_err
`endif
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(BAUD_DIV / 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BAUD_DIV - 1);

  typedef enum logic {IDLE, RECEIVE} state_t;

  state_t           state_q, state_d;
  logic             rx_p0, rx_p1, rx_p2;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [3:0]       bit_q, bit_d;
  logic [8:0]       shift_q, shift_d;
  logic [7:0]       data_d;
  logic             rdy_d;
  logic             start_det;
  logic             start_bit_unused;
`ifdef UART_RX_FRAME_CHK_EN
  logic             ferr_q, ferr_d;
`endif

  // rx_p1 is the synchronized line, rx_p2 its previous value
  assign start_det        = rx_p2 & ~rx_p1;
  // The start bit is checked live at its sample and simply shifts out at the stop sample
  assign start_bit_unused = shift_q[0];

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = rx_data;
    rdy_d   = rdy;
`ifdef UART_RX_FRAME_CHK_EN
    ferr_d  = ferr_q;
`endif
    if (clr_rdy) begin
      rdy_d = 1'b0;
`ifdef UART_RX_FRAME_CHK_EN
      ferr_d = 1'b0;
`endif
    end
    unique case (state_q)
      IDLE: begin
        if (start_det) begin
          state_d = RECEIVE;
          baud_d  = HALF_CNT;
          bit_d   = 4'd0;
          rdy_d   = 1'b0;
`ifdef UART_RX_FRAME_CHK_EN
          ferr_d  = 1'b0;
`endif
        end
      end
      RECEIVE: begin
        if (baud_q != '0) begin
          baud_d = baud_q - CNT_W'(1);
        end else begin
          shift_d = {rx_p1, shift_q[8:1]};
          bit_d   = bit_q + 4'd1;
          baud_d  = FULL_CNT;
          if (bit_q == 4'd0 && rx_p1) begin
            // Line went back high before mid-start-bit: treat as a glitch
            state_d = IDLE;
          end else if (bit_q == 4'd9) begin
            state_d = IDLE;
            data_d  = shift_q[8:1];
`ifdef UART_RX_FRAME_CHK_EN
            if (rx_p1) rdy_d = 1'b1;
            else       ferr_d = 1'b1;
`else
            rdy_d   = 1'b1;
`endif
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_p0   <= 1'b1;
      rx_p1   <= 1'b1;
      rx_p2   <= 1'b1;
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 4'd0;
      shift_q <= 9'd0;
      rx_data <= 8'h00;
      rdy     <= 1'b0;
`ifdef UART_RX_FRAME_CHK_EN
      ferr_q  <= 1'b0;
`endif
    end else begin
      rx_p0   <= RX;
      rx_p1   <= rx_p0;
      rx_p2   <= rx_p1;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rx_data <= data_d;
      rdy     <= rdy_d;
`ifdef UART_RX_FRAME_CHK_EN
      ferr_q  <= ferr_d;
`endif
    end
  end

`ifdef UART_RX_FRAME_CHK_EN
  assign framing_err = ferr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (BAUD_DIV = 20): directed frames plus an event-scheduled reference model.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int D = 20;
  localparam int H = D / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       clr_rdy = 1'b0;
  logic [7:0] rx_data;
  logic       rdy;
`ifdef UART_RX_FRAME_CHK_EN
  logic       framing_err;
`endif

  uart_rx #(.BAUD_DIV(D)) dut (
    .clk(clk),
    .rst(rst),
    .RX(rx),
    .clr_rdy(clr_rdy),
    .rx_data(rx_data),
    .rdy(rdy)
`ifdef UART_RX_FRAME_CHK_EN
    ,
    .framing_err(framing_err)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int rises = 0;
  int last_rise = 0;
  logic rdy_prev;
  bit chk_en = 1'b0;

  // Reference model: the driver schedules frame events by absolute edge number.
  // Start detect happens 3 edges after the pin falls; the result appears
  // H + 9*D + 1 edges after that (edge e0 + 4 + H + 9*D).
  bit         start_at[int];
  logic [8:0] done_at[int];
  logic       exp_rdy = 1'b0;
  logic [7:0] exp_data = 8'h00;
  logic       exp_ferr = 1'b0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk32(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_rdy  <= 1'b0;
      exp_data <= 8'h00;
      exp_ferr <= 1'b0;
      start_at.delete();
      done_at.delete();
    end else begin
      if (clr_rdy || start_at.exists(cyc + 1)) begin
        exp_rdy  <= 1'b0;
        exp_ferr <= 1'b0;
      end
      if (done_at.exists(cyc + 1)) begin
        exp_data <= done_at[cyc + 1][7:0];
`ifdef UART_RX_FRAME_CHK_EN
        if (done_at[cyc + 1][8]) exp_rdy <= 1'b1;
        else                     exp_ferr <= 1'b1;
`else
        exp_rdy <= 1'b1;
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk1("cyc_rdy", rdy, exp_rdy);
      chk8("cyc_data", rx_data, exp_data);
`ifdef UART_RX_FRAME_CHK_EN
      chk1("cyc_ferr", framing_err, exp_ferr);
`endif
    end
  end

  always @(negedge clk) begin
    if (rdy === 1'b1 && rdy_prev === 1'b0) begin
      rises     <= rises + 1;
      last_rise <= cyc;
    end
    rdy_prev <= rdy;
  end

  // Called at posedge+1; returns at posedge+1 after 10 bit periods
  task automatic send_frame(input logic [7:0] d, input logic stop, input int rst_bit,
                            output int e0);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    e0 = cyc;
    start_at[e0 + 3] = 1'b1;
    done_at[e0 + 4 + H + 9 * D] = {stop, d};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      if (i == rst_bit) begin
        rst = 1'b1;
        #1;
        chk1("rst_rdy_now", rdy, 1'b0);
        chk8("rst_data_now", rx_data, 8'h00);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (D - 3) @(posedge clk);
        #1;
      end else begin
        repeat (D) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    @(posedge clk);
    #1 clr_rdy = 1'b0;
  endtask

  initial begin
    int e0;
    int r0;
    repeat (3) @(posedge clk);
    #1;
    chk1("reset_rdy", rdy, 1'b0);
    chk8("reset_data", rx_data, 8'h00);
    chk_en = 1'b1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    r0 = rises;
    send_frame(8'hA5, 1'b1, -1, e0);
    chk8("a5_data", rx_data, 8'hA5);
    chk1("a5_rdy", rdy, 1'b1);
    chk32("a5_latency", last_rise - e0, 194);
    chk32("a5_rises", rises - r0, 1);

    r0 = rises;
    send_frame(8'h3C, 1'b1, -1, e0);
    chk8("b2b_first", rx_data, 8'h3C);
    send_frame(8'hC3, 1'b1, -1, e0);
    chk8("b2b_second", rx_data, 8'hC3);
    chk32("b2b_rises", rises - r0, 2);

    pulse_clr();
    chk1("clr_rdy_low", rdy, 1'b0);

    // Short low pulse on the line must be rejected as a glitch
    r0 = rises;
    start_at[cyc + 3] = 1'b1;
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx = 1'b1;
    repeat (12 * D) @(posedge clk);
    #1;
    chk1("glitch_rdy", rdy, 1'b0);
    chk8("glitch_data", rx_data, 8'hC3);
    chk32("glitch_rises", rises - r0, 0);

    send_frame(8'h5A, 1'b1, -1, e0);
    pulse_clr();
    chk1("clr_5a_rdy", rdy, 1'b0);
    chk8("clr_5a_data", rx_data, 8'h5A);

    fork
      send_frame(8'h5A, 1'b1, -1, e0);
      begin
        repeat (193) @(posedge clk);
        #1 clr_rdy = 1'b1;
        @(posedge clk);
        #1 clr_rdy = 1'b0;
      end
    join
    chk1("clr_vs_set_rdy", rdy, 1'b1);
    pulse_clr();

    send_frame(8'hFF, 1'b1, 5, e0);
    chk1("after_rst_rdy", rdy, 1'b0);
    chk8("after_rst_data", rx_data, 8'h00);
    send_frame(8'h81, 1'b1, -1, e0);
    chk8("post_rst_data", rx_data, 8'h81);
    chk1("post_rst_rdy", rdy, 1'b1);

    // Line held low for many bit times: exactly one all-zero frame attempted
    r0 = rises;
    e0 = cyc;
    start_at[e0 + 3] = 1'b1;
    done_at[e0 + 4 + H + 9 * D] = 9'h000;
    rx = 1'b0;
    repeat (15 * D) @(posedge clk);
    #1 rx = 1'b1;
    repeat (2 * D) @(posedge clk);
    #1;
    chk8("held_low_data", rx_data, 8'h00);
`ifdef UART_RX_FRAME_CHK_EN
    chk1("held_low_rdy", rdy, 1'b0);
    chk1("held_low_ferr", framing_err, 1'b1);
    chk32("held_low_rises", rises - r0, 0);
`else
    chk1("held_low_rdy", rdy, 1'b1);
    chk32("held_low_rises", rises - r0, 1);
`endif

    pulse_clr();
    send_frame(8'h55, 1'b0, -1, e0);
    chk8("badstop_data", rx_data, 8'h55);
`ifdef UART_RX_FRAME_CHK_EN
    chk1("badstop_rdy", rdy, 1'b0);
    chk1("badstop_ferr", framing_err, 1'b1);
`else
    chk1("badstop_rdy", rdy, 1'b1);
`endif
    rx = 1'b1;
    repeat (D) @(posedge clk);
    #1;
    send_frame(8'h12, 1'b1, -1, e0);
    chk8("good_12_data", rx_data, 8'h12);
    chk1("good_12_rdy", rdy, 1'b1);
`ifdef UART_RX_FRAME_CHK_EN
    chk1("good_12_ferr", framing_err, 1'b0);
`endif

    repeat (10) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
